// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_divider_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;
    localparam int unsigned MAX_WIDTH     = 64;

    // Quotient reported on divide by zero, cast down to the instance width
    localparam logic [MAX_WIDTH-1:0] DIV_ZERO_QUOTIENT = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/Counter.sv
// Generic up-counter with synchronous clear and count enable.
module Counter #(
    parameter int unsigned SIZE = 4
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic            Clear,
    input  logic            Enable,
    output logic [SIZE-1:0] Count
);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            Count <= '0;
        end else if (Clear) begin
            Count <= '0;
        end else if (Enable) begin
            Count <= Count + SIZE'(1);
        end
    end

endmodule

// File: rtl/div_step.sv
// One restoring shift-subtract iteration: shift in the dividend MSB, subtract if it fits.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             dq_msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    // Keep the bit shifted out of rem so divisors near 2^WIDTH still compare correctly
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    assign shifted  = {rem, dq_msb};
    assign diff     = shifted - {1'b0, divisor};
    assign q_bit    = (shifted >= {1'b0, divisor});
    assign rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per clock, start/done handshake.
// Define SEQ_DIVIDER_SIGNED_EN for two's complement operands (sign fix-up in FIX).
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             iStart,
    input  logic [WIDTH-1:0] iDividend,
    input  logic [WIDTH-1:0] iDivisor,
    output logic             oBusy,
    output logic             oDone,
    output logic [WIDTH-1:0] oQuotient,
    output logic [WIDTH-1:0] oRemainder,
    output logic             oDivByZero
);

    state_t           state;
    state_t           next_state;
    logic             start_accept;
    logic [CNT_W-1:0] step_count;

    logic [WIDTH-1:0] dq;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] divisor;
    logic             div_zero;
    logic [WIDTH-1:0] rem_next;
    logic             q_bit;

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic [WIDTH-1:0] dividend_raw;
    logic             sign_dividend;
    logic             sign_divisor;
`endif

    Counter #(.SIZE(CNT_W)) u_step_counter (
        .Clock  (Clock),
        .Reset  (Reset),
        .Clear  (start_accept),
        .Enable (state == RUN),
        .Count  (step_count)
    );

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem      (rem),
        .dq_msb   (dq[WIDTH-1]),
        .divisor  (divisor),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state   = state;
        start_accept = 1'b0;
        case (state)
            IDLE: begin
                if (iStart) begin
                    start_accept = 1'b1;
                    next_state   = (iDivisor == '0) ? DONE : RUN;
                end
            end
            RUN:     if (step_count == CNT_W'(WIDTH - 1)) next_state = FIX;
            FIX:     next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath and registered outputs; results are published from the DONE cycle
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            dq         <= '0;
            rem        <= '0;
            divisor    <= '0;
            div_zero   <= 1'b0;
            oBusy      <= 1'b0;
            oDone      <= 1'b0;
            oQuotient  <= '0;
            oRemainder <= '0;
            oDivByZero <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            dividend_raw  <= '0;
            sign_dividend <= 1'b0;
            sign_divisor  <= 1'b0;
`endif
        end else begin
            oDone <= 1'b0;
            oBusy <= (next_state == RUN) || (next_state == FIX);
            case (state)
                IDLE: begin
                    if (start_accept) begin
                        rem        <= '0;
                        div_zero   <= (iDivisor == '0);
                        oDivByZero <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
                        dividend_raw  <= iDividend;
                        sign_dividend <= iDividend[WIDTH-1];
                        sign_divisor  <= iDivisor[WIDTH-1];
                        dq      <= iDividend[WIDTH-1] ? (~iDividend + WIDTH'(1)) : iDividend;
                        divisor <= iDivisor[WIDTH-1]  ? (~iDivisor + WIDTH'(1))  : iDivisor;
`else
                        dq      <= iDividend;
                        divisor <= iDivisor;
`endif
                    end
                end
                RUN: begin
                    dq  <= {dq[WIDTH-2:0], q_bit};
                    rem <= rem_next;
                end
                FIX: begin
`ifdef SEQ_DIVIDER_SIGNED_EN
                    if (sign_dividend ^ sign_divisor) dq <= ~dq + WIDTH'(1);
                    if (sign_dividend)                rem <= ~rem + WIDTH'(1);
`endif
                end
                DONE: begin
                    oDone      <= 1'b1;
                    oDivByZero <= div_zero;
                    if (div_zero) begin
                        oQuotient <= WIDTH'(DIV_ZERO_QUOTIENT);
`ifdef SEQ_DIVIDER_SIGNED_EN
                        oRemainder <= dividend_raw;
`else
                        oRemainder <= dq;
`endif
                    end else begin
                        oQuotient  <= dq;
                        oRemainder <= rem;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: directed corner cases plus random operands.
module tb_seq_divider;

    localparam int unsigned W = 32;

    logic         Clock;
    logic         Reset;
    logic         iStart;
    logic [W-1:0] iDividend;
    logic [W-1:0] iDivisor;
    logic         oBusy;
    logic         oDone;
    logic [W-1:0] oQuotient;
    logic [W-1:0] oRemainder;
    logic         oDivByZero;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        longint       due;
    } exp_t;

    exp_t   sb_q[$];
    longint cyc;
    int     n_checks;
    int     n_fail;

    seq_divider #(.WIDTH(W)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .iStart     (iStart),
        .iDividend  (iDividend),
        .iDivisor   (iDivisor),
        .oBusy      (oBusy),
        .oDone      (oDone),
        .oQuotient  (oQuotient),
        .oRemainder (oRemainder),
        .oDivByZero (oDivByZero)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain arithmetic on the operand values
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input longint due);
        exp_t e;
        e.due = due;
        e.dz  = (b == '0);
        if (b == '0) begin
            e.q = '1;
            e.r = a;
        end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
            longint sa;
            longint sb;
            sa  = longint'($signed(a));
            sb  = longint'($signed(b));
            e.q = W'(sa / sb);
            e.r = W'(sa % sb);
`else
            e.q = a / b;
            e.r = a % b;
`endif
        end
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding request
    always @(negedge Clock) begin
        if (!Reset && oDone) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 64'(oDone), 64'(0));
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("quotient",   64'(oQuotient),  64'(e.q));
                check("remainder",  64'(oRemainder), 64'(e.r));
                check("div_by_zero",64'(oDivByZero), 64'(e.dz));
                check("latency",    64'(cyc),        64'(e.due));
            end
        end
    end

    // Issue one division; optionally pulse a stray start with 20/4 at step inject
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int inject);
        longint lat;
        bit     seen;
        lat = (b == '0) ? 64'd1 : 64'(W + 2);
        @(negedge Clock);
        iStart    = 1'b1;
        iDividend = a;
        iDivisor  = b;
        sb_q.push_back(model(a, b, cyc + 1 + lat));
        @(negedge Clock);
        iStart    = 1'b0;
        iDividend = $urandom;
        iDivisor  = $urandom;
        check("busy_after_start", 64'(oBusy), 64'(b != '0));
        seen = oDone;
        for (int k = 1; k < 100 && !seen; k++) begin
            @(negedge Clock);
            if (inject != 0 && k == inject) begin
                iStart    = 1'b1;
                iDividend = 32'd20;
                iDivisor  = 32'd4;
            end else begin
                iStart = 1'b0;
            end
            seen = oDone;
        end
        iStart = 1'b0;
        if (!seen) begin
            check("done_timeout", 64'(0), 64'(1));
        end else begin
            check("busy_at_done", 64'(oBusy), 64'(0));
            @(negedge Clock);
            check("done_single_pulse", 64'(oDone), 64'(0));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 64'(oBusy),      64'(0));
        check({tag, "_done"}, 64'(oDone),      64'(0));
        check({tag, "_q"},    64'(oQuotient),  64'(0));
        check({tag, "_r"},    64'(oRemainder), 64'(0));
        check({tag, "_dz"},   64'(oDivByZero), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        n_checks  = 0;
        n_fail    = 0;
        cyc       = 0;
        Reset     = 1'b1;
        iStart    = 1'b0;
        iDividend = '0;
        iDivisor  = '0;
        repeat (3) @(negedge Clock);
        check_all_zero("reset");
        Reset = 1'b0;

        run_op(32'd100, 32'd7, 0);
        run_op(32'd5, 32'd0, 0);
        run_op(32'd9, 32'd3, 0);
        run_op(32'd3, 32'd10, 0);
        run_op(32'hFFFF_FFFF, 32'd1, 0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(32'd1000, 32'd3, 10);

        // Asynchronous reset in the middle of an operation
        @(negedge Clock);
        iStart    = 1'b1;
        iDividend = 32'd1000;
        iDivisor  = 32'd3;
        @(negedge Clock);
        iStart = 1'b0;
        repeat (14) @(negedge Clock);
        #2 Reset = 1'b1;
        #1 check_all_zero("async_reset");
        sb_q.delete();
        @(negedge Clock);
        Reset = 1'b0;
        run_op(32'd50, 32'd5, 0);

`ifdef SEQ_DIVIDER_SIGNED_EN
        run_op(-32'sd7, 32'sd2, 0);
        run_op(32'sd7, -32'sd2, 0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(-32'sd9, 32'd0, 0);
`endif

        for (int i = 0; i < 150; i++) begin
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = '0;
                1, 2:    b = W'($urandom_range(1, 255));
                3:       b = a >> $urandom_range(0, 31);
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(0, 31);
            run_op(a, b, 0);
        end

        repeat (3) @(negedge Clock);
        check("scoreboard_drained", 64'(sb_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
